// File: rtl/simple_proc_pkg.sv
// ============================================================================
// simple_proc_pkg : shared widths, opcode and FSM state encodings
// Revision 1.0
// ============================================================================
`default_nettype none

package simple_proc_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 5;
  localparam int OPC_W      = 3;

  typedef enum logic [OPC_W-1:0] {
    OP_LDA  = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_AND  = 3'd3,
    OP_OUT  = 3'd4,
    OP_JMP  = 3'd5,
    OP_JZ   = 3'd6,
    OP_HALT = 3'd7
  } opcode_t;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/simple_proc_alu.sv
// ============================================================================
// simple_proc_alu : next-accumulator value and zero test for the EXEC state
// Revision 1.0
// ============================================================================
`default_nettype none

module simple_proc_alu
  import simple_proc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  opcode_t           opcode_i,
  input  logic [DATA_W-1:0] acc_i,
  input  logic [DATA_W-1:0] datain_i,
  output logic [DATA_W-1:0] acc_next_o,
  output logic              zero_o
);

  // Non-arithmetic opcodes leave the accumulator untouched.
  always_comb begin
    acc_next_o = acc_i;
    unique case (opcode_i)
      OP_LDA:  acc_next_o = datain_i;
      OP_ADD:  acc_next_o = acc_i + datain_i;
      OP_SUB:  acc_next_o = acc_i - datain_i;
      OP_AND:  acc_next_o = acc_i & datain_i;
      default: acc_next_o = acc_i;
    endcase
  end

  assign zero_o = (acc_i == '0);

endmodule

`default_nettype wire

// File: rtl/simple_proc.sv
// ============================================================================
// simple_proc : two-cycle FETCH/EXEC 8-bit accumulator processor
// Revision 1.0
// ============================================================================
`default_nettype none

module simple_proc
  import simple_proc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [DATA_W-1:0] datain,
  output logic [DATA_W-1:0] dataout,
  output logic [ADDR_W-1:0] address
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q,    pc_d;
  logic [DATA_W-1:0] ir_q,    ir_d;
  logic [DATA_W-1:0] acc_q,   acc_d;
  logic [DATA_W-1:0] dout_q,  dout_d;

  opcode_t           opcode;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W-1:0] alu_acc;
  logic              acc_zero;

  assign opcode  = opcode_t'(ir_q[DATA_W-1 -: OPC_W]);
  assign operand = ir_q[ADDR_W-1:0];

  simple_proc_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .opcode_i   (opcode),
    .acc_i      (acc_q),
    .datain_i   (datain),
    .acc_next_o (alu_acc),
    .zero_o     (acc_zero)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      acc_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      dout_q  <= dout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    acc_d   = acc_q;
    dout_d  = dout_q;
    unique case (state_q)
      ST_FETCH: begin
        ir_d    = datain;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        acc_d   = alu_acc;
        state_d = ST_FETCH;
        // Jump targets replace the pc that FETCH already advanced.
        unique case (opcode)
          OP_OUT:  dout_d  = acc_q;
          OP_JMP:  pc_d    = operand;
          OP_JZ:   if (acc_zero) pc_d = operand;
          OP_HALT: state_d = ST_HALT;
          default: ;
        endcase
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  assign address = (state_q == ST_EXEC) ? operand : pc_q;
  assign dataout = dout_q;

endmodule

`default_nettype wire

// File: tb/tb_simple_proc.sv
// ============================================================================
// tb_simple_proc : directed vector table plus reset, jump and wrap sequences
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_simple_proc;

  logic       clk;
  logic       nrst;
  logic [7:0] datain;
  logic [7:0] dataout;
  logic [4:0] address;
  logic [7:0] mem [32];

  int n_tests = 0;
  int n_fail  = 0;

  simple_proc dut (
    .clk     (clk),
    .nrst    (nrst),
    .datain  (datain),
    .dataout (dataout),
    .address (address)
  );

  assign datain = mem[address];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program: LDA 16 ; i1 ; OUT ; HALT  with mem[16]=d0, mem[17]=d1
  typedef struct {
    logic [7:0] i1;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] exp_out;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int k = 0; k < 32; k++) mem[k] = 8'h00;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    #1;
  endtask

  initial begin
    vecs[0] = '{i1: 8'h31, d0: 8'h05, d1: 8'h07, exp_out: 8'h0C};
    vecs[1] = '{i1: 8'h51, d0: 8'h03, d1: 8'h05, exp_out: 8'hFE};
    vecs[2] = '{i1: 8'h31, d0: 8'hF0, d1: 8'h20, exp_out: 8'h10};
    vecs[3] = '{i1: 8'h71, d0: 8'hF0, d1: 8'h3C, exp_out: 8'h30};
    vecs[4] = '{i1: 8'h11, d0: 8'hAA, d1: 8'h55, exp_out: 8'h55};
    vecs[5] = '{i1: 8'h51, d0: 8'h80, d1: 8'h81, exp_out: 8'hFF};

    clear_mem();
    nrst = 1'b1;
    #2 nrst = 1'b0;
    #1;
    check("reset_dataout", dataout, 8'h00);
    check("reset_address", {3'b0, address}, 8'h00);
    repeat (3) @(posedge clk);
    #2 nrst = 1'b1;
    #1;
    check("release_address", {3'b0, address}, 8'h00);

    // Add program with full address trace
    clear_mem();
    mem[0] = 8'h0A; mem[1] = 8'h2B; mem[2] = 8'h80; mem[3] = 8'hE0;
    mem[10] = 8'h05; mem[11] = 8'h07;
    do_reset();
    check("add_addr_e0", {3'b0, address}, 8'd0);
    step(1); check("add_addr_e1", {3'b0, address}, 8'd10);
    step(1); check("add_addr_e2", {3'b0, address}, 8'd1);
    step(1); check("add_addr_e3", {3'b0, address}, 8'd11);
    step(1); check("add_addr_e4", {3'b0, address}, 8'd2);
    check("add_dout_e4", dataout, 8'h00);
    step(1);
    step(1); check("add_addr_e6", {3'b0, address}, 8'd3);
    check("add_dout_e6", dataout, 8'h0C);
    step(2); check("add_halt_e8", {3'b0, address}, 8'd4);
    step(4); check("add_halt_e12", {3'b0, address}, 8'd4);
    check("add_halt_dout", dataout, 8'h0C);

    for (int v = 0; v < 6; v++) begin
      clear_mem();
      mem[0] = 8'h10; mem[1] = vecs[v].i1; mem[2] = 8'h80; mem[3] = 8'hE0;
      mem[16] = vecs[v].d0; mem[17] = vecs[v].d1;
      do_reset();
      step(10);
      check($sformatf("vec%0d_dataout", v), dataout, vecs[v].exp_out);
      check($sformatf("vec%0d_halt_addr", v), {3'b0, address}, 8'd4);
    end

    // JZ taken (acc==0) and not taken (acc==1)
    for (int z = 0; z < 2; z++) begin
      clear_mem();
      mem[0] = 8'h10; mem[1] = 8'hD4; mem[2] = 8'hE0; mem[20] = 8'hE0;
      mem[16] = (z == 0) ? 8'h00 : 8'h01;
      do_reset();
      step(4);
      check($sformatf("jz_acc%0d_addr", z), {3'b0, address}, (z == 0) ? 8'd20 : 8'd2);
    end

    // JMP 31 then LDA 0 at 31: pc wraps to 0
    clear_mem();
    mem[0] = 8'hBF; mem[31] = 8'h00;
    do_reset();
    step(2); check("jmp_addr31", {3'b0, address}, 8'd31);
    step(2); check("pc_wrap_addr0", {3'b0, address}, 8'd0);

    // Reset asserted during EXEC of OUT with acc=0x55
    clear_mem();
    mem[0] = 8'h10; mem[1] = 8'h80; mem[2] = 8'hE0; mem[16] = 8'h55;
    do_reset();
    step(3);
    check("midrst_exec_addr", {3'b0, address}, 8'd0);
    #2 nrst = 1'b0;
    #1;
    check("midrst_dout_async", dataout, 8'h00);
    check("midrst_addr_async", {3'b0, address}, 8'd0);
    step(1);
    check("midrst_dout_held", dataout, 8'h00);
    @(negedge clk);
    nrst = 1'b1;
    #1;
    check("midrst_release_addr", {3'b0, address}, 8'd0);
    step(1); check("midrst_refetch_addr", {3'b0, address}, 8'd16);
    step(3); check("midrst_rerun_dout", dataout, 8'h55);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
